// File: rtl/note_acceptor_frontend.sv
// ---------------------------------------------------------------------------
// NoteAcceptorFrontend
//
// Front end of the vending payment path. It takes the two raw, bouncing note
// slot switches, synchronises and debounces them, and turns one physical
// insertion into exactly one single-cycle note code for the downstream
// money-accumulation FSM. Simultaneous insertions, and insertions that arrive
// before the acceptor has settled after the previous note, are rejected.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a synchronised level must persist to be accepted
//   LOCKOUT_CYCLES   idle cycles required after release before a new note
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-high
//   btn_note10     raw 10 EUR slot switch (asynchronous, active-high)
//   btn_note20     raw 20 EUR slot switch (asynchronous, active-high)
//   enable         high when the acceptor may take notes
//   inputMoney     5'd10 / 5'd20 for one cycle per accepted note, else 0
//   note_valid     high exactly when inputMoney is non-zero
//   note_rejected  one-cycle pulse on a simultaneous or too-early insertion
//   busy           high whenever the acceptor is not idle
// ---------------------------------------------------------------------------
module note_acceptor_frontend #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int LOCKOUT_CYCLES  = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_note10,
   input  logic       btn_note20,
   input  logic       enable,
   output logic [4:0] inputMoney,
   output logic       note_valid,
   output logic       note_rejected,
   output logic       busy
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int SW = $clog2(DEBOUNCE_CYCLES + 3);
   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES);
   localparam logic [SW-1:0] START_LAST = SW'(DEBOUNCE_CYCLES + 2);
   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      STARTUP,
      IDLE,
      EMIT,
      WAIT_REL,
      LOCKOUT
   } stateT;

   // Index 0 is the 10 EUR slot, index 1 the 20 EUR slot.
   logic [1:0]    s1;
   logic [1:0]    s2;
   logic [1:0]    deb;
   logic [DW-1:0] debCnt [2];

   stateT         state;
   logic [SW-1:0] startCnt;
   logic [LW-1:0] lockCnt;

   // Two-flop synchroniser followed by a per-slot debouncer. A synchronised
   // level only replaces the accepted level after it has disagreed with it on
   // DEBOUNCE_CYCLES+1 consecutive samples; any agreeing sample restarts the
   // count, so short bounces never reach the FSM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1        <= 2'b00;
         s2        <= 2'b00;
         deb       <= 2'b00;
         debCnt[0] <= '0;
         debCnt[1] <= '0;
      end else begin
         s1 <= {btn_note20, btn_note10};
         s2 <= s1;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] != deb[i]) begin
               if (debCnt[i] == DEB_LAST) begin
                  deb[i]    <= s2[i];
                  debCnt[i] <= '0;
               end else begin
                  debCnt[i] <= debCnt[i] + DW'(1);
               end
            end else begin
               debCnt[i] <= '0;
            end
         end
      end
   end

   // Acceptance FSM with registered outputs. STARTUP outlasts the debounce
   // latency so a switch held through reset is seen as already pressed and
   // routed to WAIT_REL instead of producing a note. Every exit from a press
   // goes through WAIT_REL and a full LOCKOUT, which is what guarantees the
   // minimum spacing between codes. Only the accepted (debounced) levels are
   // used here; EMIT ignores the slots entirely so a second slot activated
   // mid-note is silently absorbed by WAIT_REL.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= STARTUP;
         startCnt      <= '0;
         lockCnt       <= '0;
         inputMoney    <= 5'd0;
         note_valid    <= 1'b0;
         note_rejected <= 1'b0;
         busy          <= 1'b0;
      end else begin
         inputMoney    <= 5'd0;
         note_valid    <= 1'b0;
         note_rejected <= 1'b0;
         busy          <= 1'b1;
         case (state)
            STARTUP: begin
               if (startCnt == START_LAST) begin
                  startCnt <= '0;
                  state    <= WAIT_REL;
               end else begin
                  startCnt <= startCnt + SW'(1);
               end
            end
            IDLE: begin
               if (deb == 2'b11) begin
                  note_rejected <= 1'b1;
                  state         <= WAIT_REL;
               end else if (deb != 2'b00) begin
                  if (enable) begin
                     inputMoney <= deb[0] ? 5'd10 : 5'd20;
                     note_valid <= 1'b1;
                     state      <= EMIT;
                  end else begin
                     state <= WAIT_REL;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            EMIT: begin
               state <= WAIT_REL;
            end
            WAIT_REL: begin
               if (deb == 2'b00) begin
                  lockCnt <= '0;
                  state   <= LOCKOUT;
               end
            end
            LOCKOUT: begin
               if (deb != 2'b00) begin
                  note_rejected <= 1'b1;
                  state         <= WAIT_REL;
               end else if (lockCnt == LOCK_LAST) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  lockCnt <= lockCnt + LW'(1);
               end
            end
            default: begin
               state <= STARTUP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_acceptor_frontend.sv
// ---------------------------------------------------------------------------
// Testbench for note_acceptor_frontend (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8).
//
// A behavioural model tracks the expected outputs every cycle; on top of it a
// table of single-press scenarios, several hand-written multi-cycle corner
// cases and a randomised stretch of switch activity are applied.
// ---------------------------------------------------------------------------
module tb_note_acceptor_frontend;

   localparam int D = 4;
   localparam int L = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       btn_note10 = 1'b0;
   logic       btn_note20 = 1'b0;
   logic       enable = 1'b1;
   logic [4:0] inputMoney;
   logic       note_valid;
   logic       note_rejected;
   logic       busy;

   note_acceptor_frontend #(
      .DEBOUNCE_CYCLES(D),
      .LOCKOUT_CYCLES (L)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .btn_note10   (btn_note10),
      .btn_note20   (btn_note20),
      .enable       (enable),
      .inputMoney   (inputMoney),
      .note_valid   (note_valid),
      .note_rejected(note_rejected),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int codes10 = 0;
   int codes20 = 0;
   int rejects = 0;
   int sinceCode = 1000;

   // Reference model. Switch history is kept as "raw value one / two edges
   // ago"; a slot is considered inserted once its synchronised value has
   // disagreed with the accepted value for D+1 samples in a row. Acceptance
   // is tracked with countdowns and flags rather than a state encoding.
   typedef struct packed {
      logic [1:0]      ago1;
      logic [1:0]      ago2;
      logic [1:0]      deb;
      logic [1:0][7:0] run;
      int              startupLeft;
      logic            waitRel;
      int              quietLeft;
      logic            emitted;
      logic [4:0]      money;
      logic            valid;
      logic            rej;
      logic            busy;
   } modelT;

   function automatic modelT modelReset();
      modelT m;
      m = '0;
      m.startupLeft = D + 3;
      return m;
   endfunction

   function automatic modelT stepModel(modelT m, logic r10, logic r20, logic en);
      modelT n;
      logic  any;
      logic  both;
      n       = m;
      any     = m.deb[0] | m.deb[1];
      both    = m.deb[0] & m.deb[1];
      n.money = 5'd0;
      n.valid = 1'b0;
      n.rej   = 1'b0;
      if (m.startupLeft > 0) begin
         n.startupLeft = m.startupLeft - 1;
         if (n.startupLeft == 0) n.waitRel = 1'b1;
      end else if (m.emitted) begin
         n.emitted = 1'b0;
         n.waitRel = 1'b1;
      end else if (m.waitRel) begin
         if (!any) begin
            n.waitRel   = 1'b0;
            n.quietLeft = L;
         end
      end else if (m.quietLeft > 0) begin
         if (any) begin
            n.rej       = 1'b1;
            n.quietLeft = 0;
            n.waitRel   = 1'b1;
         end else begin
            n.quietLeft = m.quietLeft - 1;
         end
      end else if (both) begin
         n.rej     = 1'b1;
         n.waitRel = 1'b1;
      end else if (any) begin
         if (en) begin
            n.money   = m.deb[0] ? 5'd10 : 5'd20;
            n.valid   = 1'b1;
            n.emitted = 1'b1;
         end else begin
            n.waitRel = 1'b1;
         end
      end
      n.busy = (n.startupLeft > 0) || n.emitted || n.waitRel || (n.quietLeft > 0);
      for (int i = 0; i < 2; i++) begin
         if (m.ago2[i] != m.deb[i]) begin
            n.run[i] = m.run[i] + 8'd1;
            if (n.run[i] == 8'(D + 1)) begin
               n.deb[i] = m.ago2[i];
               n.run[i] = 8'd0;
            end
         end else begin
            n.run[i] = 8'd0;
         end
      end
      n.ago2 = m.ago1;
      n.ago1 = {r20, r10};
      return n;
   endfunction

   modelT model = modelReset();

   // Advance the model on every edge, mirroring the asynchronous reset.
   always @(posedge clock or posedge reset) begin
      if (reset) model <= modelReset();
      else       model <= stepModel(model, btn_note10, btn_note20, enable);
   end

   task automatic checkOutput();
      checks++;
      if ({inputMoney, note_valid, note_rejected, busy} !==
          {model.money, model.valid, model.rej, model.busy}) begin
         errors++;
         $display("[TB] FAIL cycleModel t=%0t: money=%0d valid=%0b rej=%0b busy=%0b, required money=%0d valid=%0b rej=%0b busy=%0b",
                  $time, inputMoney, note_valid, note_rejected, busy,
                  model.money, model.valid, model.rej, model.busy);
      end
   endtask

   // Per-cycle comparison, pulse counting and code-spacing check, all done on
   // the falling edge so the DUT and model have settled.
   always @(negedge clock) begin
      checkOutput();
      if (reset) begin
         sinceCode = 1000;
      end else begin
         if (note_rejected) rejects++;
         if (note_valid) begin
            if (inputMoney == 5'd10) codes10++;
            if (inputMoney == 5'd20) codes20++;
            if (sinceCode < 1000) begin
               checks++;
               if (sinceCode + 1 < L + 2) begin
                  errors++;
                  $display("[TB] FAIL codeSpacing t=%0t: gap=%0d cycles, required >= %0d",
                           $time, sinceCode + 1, L + 2);
               end
            end
            sinceCode = 0;
         end else if (sinceCode < 1000) begin
            sinceCode++;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic checkAllZero(input string name);
      checks++;
      if ({inputMoney, note_valid, note_rejected, busy} !== 8'd0) begin
         errors++;
         $display("[TB] FAIL %s: money=%0d valid=%0b rej=%0b busy=%0b, required all 0",
                  name, inputMoney, note_valid, note_rejected, busy);
      end
   endtask

   task automatic checkCounts(input string name, input int got10, input int got20, input int gotRej,
                              input int exp10, input int exp20, input int expRej);
      checks++;
      if (got10 != exp10 || got20 != exp20 || gotRej != expRej) begin
         errors++;
         $display("[TB] FAIL %s: codes10=%0d codes20=%0d rejects=%0d, required %0d/%0d/%0d",
                  name, got10, got20, gotRej, exp10, exp20, expRej);
      end
   endtask

   // The stable level must already be driven; the code has to appear right
   // after the expEdges-th rising edge.
   task automatic waitForCode(input string name, input logic [4:0] expCode, input int expEdges);
      int         found;
      logic [4:0] gotMoney;
      found    = 0;
      gotMoney = 5'd0;
      for (int k = 1; k <= expEdges + 12 && found == 0; k++) begin
         @(posedge clock);
         #1;
         if (note_valid) begin
            found    = k;
            gotMoney = inputMoney;
         end
      end
      checks++;
      if (found != expEdges || gotMoney != expCode) begin
         errors++;
         $display("[TB] FAIL %s: code %0d after %0d edges, required %0d after %0d edges",
                  name, gotMoney, found, expCode, expEdges);
      end
   endtask

   typedef struct {
      bit    b10;
      bit    b20;
      bit    en;
      int    holdCycles;
      int    exp10;
      int    exp20;
      int    expRej;
      string name;
   } vecT;

   task automatic applyStimulus(input vecT v);
      int c10, c20, cr;
      c10 = codes10;
      c20 = codes20;
      cr  = rejects;
      enable     = v.en;
      btn_note10 = v.b10;
      btn_note20 = v.b20;
      repeat (v.holdCycles) tick();
      btn_note10 = 1'b0;
      btn_note20 = 1'b0;
      repeat (30) tick();
      enable = 1'b1;
      checkCounts(v.name, codes10 - c10, codes20 - c20, rejects - cr, v.exp10, v.exp20, v.expRej);
   endtask

   initial begin
      vecT vecs[8];
      int  c10, c20, cr;

      vecs[0] = '{1, 0, 1, 10, 1, 0, 0, "clean10"};
      vecs[1] = '{0, 1, 1, 10, 0, 1, 0, "clean20"};
      vecs[2] = '{1, 1, 1, 10, 0, 0, 1, "bothSlots"};
      vecs[3] = '{1, 0, 1,  3, 0, 0, 0, "glitch3"};
      vecs[4] = '{1, 0, 1,  4, 0, 0, 0, "belowThreshold4"};
      vecs[5] = '{1, 0, 1,  5, 1, 0, 0, "atThreshold5"};
      vecs[6] = '{0, 1, 0, 10, 0, 0, 0, "disabled20"};
      vecs[7] = '{1, 1, 0, 10, 0, 0, 1, "bothDisabled"};

      reset = 1'b1;
      repeat (3) tick();
      checkAllZero("resetState");
      reset = 1'b0;
      repeat (25) tick();

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Clean 10 EUR press: code 8 edges after the first sampled high.
      btn_note10 = 1'b1;
      waitForCode("latency10", 5'd10, D + 4);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busyAfterCode: busy=%0b, required 1", busy);
      end
      repeat (5) tick();
      btn_note10 = 1'b0;
      repeat (30) tick();

      // Bouncing 20 EUR insertion followed by a stable level.
      c20 = codes20;
      for (int i = 0; i < 6; i++) begin
         btn_note20 = (i % 2 == 0);
         tick();
      end
      btn_note20 = 1'b1;
      waitForCode("bounce20", 5'd20, D + 4);
      repeat (8) tick();
      btn_note20 = 1'b0;
      repeat (30) tick();
      checkCounts("bounceSingleCode", 0, codes20 - c20, 0, 0, 1, 0);

      // Note, short release, re-press that matures during lockout.
      btn_note10 = 1'b1;
      repeat (10) tick();
      btn_note10 = 1'b0;
      repeat (6) tick();
      c10 = codes10;
      cr  = rejects;
      btn_note10 = 1'b1;
      repeat (10) tick();
      btn_note10 = 1'b0;
      repeat (30) tick();
      checkCounts("lockoutRepress", codes10 - c10, 0, rejects - cr, 0, 0, 1);
      btn_note10 = 1'b1;
      waitForCode("afterLockout", 5'd10, D + 4);
      repeat (5) tick();
      btn_note10 = 1'b0;
      repeat (30) tick();

      // Switch held through reset deassertion.
      btn_note10 = 1'b1;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      c10 = codes10;
      repeat (30) tick();
      btn_note10 = 1'b0;
      repeat (30) tick();
      checkCounts("heldThroughReset", codes10 - c10, 0, 0, 0, 0, 0);
      btn_note10 = 1'b1;
      waitForCode("afterHeldReset", 5'd10, D + 4);
      repeat (5) tick();
      btn_note10 = 1'b0;
      repeat (30) tick();

      // Press while disabled, enable raised while still held.
      c10 = codes10;
      enable = 1'b0;
      btn_note10 = 1'b1;
      repeat (12) tick();
      enable = 1'b1;
      repeat (10) tick();
      btn_note10 = 1'b0;
      repeat (30) tick();
      checkCounts("enableWhileHeld", codes10 - c10, 0, 0, 0, 0, 0);

      // Reset asserted the cycle before the code would be emitted.
      c10 = codes10;
      btn_note10 = 1'b1;
      repeat (D + 3) tick();
      reset = 1'b1;
      repeat (2) tick();
      checkAllZero("resetBeforeEmit");
      btn_note10 = 1'b0;
      reset = 1'b0;
      repeat (30) tick();
      checkCounts("abortedEmit", codes10 - c10, 0, 0, 0, 0, 0);

      // Randomised switch activity, checked cycle by cycle against the model.
      for (int seg = 0; seg < 80; seg++) begin
         if ($urandom_range(0, 24) == 0) begin
            reset = 1'b1;
            repeat (2) tick();
            reset = 1'b0;
         end
         btn_note10 = ($urandom_range(0, 2) == 0);
         btn_note20 = ($urandom_range(0, 3) == 0);
         enable     = ($urandom_range(0, 4) != 0);
         repeat ($urandom_range(1, 14)) tick();
      end
      btn_note10 = 1'b0;
      btn_note20 = 1'b0;
      enable     = 1'b1;
      repeat (30) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
